commit_trace_buffer: RTL and testbench

Captures one commit record per clock from the single-cycle processor's observation outputs (PC, instruction, ALU result, write-back data, control flags) into a circular FIFO. Exposes the records on a valid/ready drain port for the bench scoreboard or a debug serializer. Sits directly downstream of `Processor`, replacing free-running `$monitor` printing with a lossless-until-full, sequence-numbered trace.

---
 rtl/commit_trace_buffer_if.sv | 24 ++
 rtl/commit_trace_buffer.sv | 107 ++++++++++
 tb/tb_commit_trace_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Drain port of the commit trace buffer: valid/ready handshake carrying one
// commit record (PC, instruction, ALU result, write-back data, flags, sequence).
interface commit_trace_buffer_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_alu;
    logic [XLEN-1:0] out_wdata;
    logic [2:0]      out_flags;
    logic [15:0]     out_seq;

    modport master (
        output out_valid, out_pc, out_instr, out_alu, out_wdata, out_flags, out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_instr, out_alu, out_wdata, out_flags, out_seq,
        output out_ready
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular FIFO recording one sequence-numbered commit record per clock from the
// processor's observation outputs; drained over a valid/ready port, drops counted.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [XLEN-1:0]          pc,
    input  logic [XLEN-1:0]          instruction,
    input  logic [XLEN-1:0]          ALU_result,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     RegWrite,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    commit_trace_buffer_if.master    drain,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              drop_cnt,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 4 * XLEN + 3 + 16;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic [15:0]      r_seq;
    logic [15:0]      r_drop_cnt;
    logic             r_overflow;

    logic             w_try;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW:0]      w_count_nxt;
    logic [REC_W-1:0] w_head;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // An all-zero instruction is a reset bubble and never consumes a sequence number.
    assign w_try  = cap_en && (instruction != '0);
    assign w_pop  = !r_empty && drain.out_ready;
    assign w_push = w_try && (!r_full || w_pop);
    assign w_drop = w_try && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is data only: not reset, a stale slot is harmless once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pc, instruction, ALU_result, write_data,
                                RegWrite, MemRead, MemWrite, r_seq};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            // Dropped captures still advance seq so gaps in out_seq expose losses.
            if (w_try) r_seq <= r_seq + 16'd1;
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign drain.out_valid = !r_empty;
    assign {drain.out_pc, drain.out_instr, drain.out_alu, drain.out_wdata,
            drain.out_flags, drain.out_seq} = w_head;

    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a queue-based reference model predicts
// stored records and status; a negedge monitor checks every popped record.
module tb_commit_trace_buffer;
    localparam int DEPTH = 16;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            cap_en;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] ALU_result;
    logic [XLEN-1:0] write_data;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic [4:0]      count;
    logic            full;
    logic            empty;
    logic [15:0]     drop_cnt;
    logic            overflow;

    commit_trace_buffer_if #(.XLEN(XLEN)) u_if ();

    commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (cap_en),
        .pc          (pc),
        .instruction (instruction),
        .ALU_result  (ALU_result),
        .write_data  (write_data),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .drain       (u_if),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [2:0]  flags;
        logic [15:0] seq;
    } rec_t;

    rec_t        exp_q[$];
    int          m_cnt;
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    bit          m_ovf;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record monitor: a handshake seen before the edge is a pop on that edge.
    always @(negedge clk) begin
        rec_t e;
        if (rst === 1'b0 && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got seq %0h, expected no record", u_if.out_seq);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc",    u_if.out_pc,    e.pc);
                chk("pop_instr", u_if.out_instr, e.instr);
                chk("pop_alu",   u_if.out_alu,   e.alu);
                chk("pop_wdata", u_if.out_wdata, e.wdata);
                chk("pop_flags", u_if.out_flags, e.flags);
                chk("pop_seq",   u_if.out_seq,   e.seq);
            end
        end
    end

    task automatic check_status();
        chk("count",    count,        m_cnt);
        chk("full",     full,         m_cnt == DEPTH);
        chk("empty",    empty,        m_cnt == 0);
        chk("valid",    u_if.out_valid, m_cnt != 0);
        chk("drop_cnt", drop_cnt,     m_drop);
        chk("overflow", overflow,     m_ovf);
        if (m_cnt > 0 && exp_q.size() > 0) begin
            chk("head_pc",  u_if.out_pc,  exp_q[0].pc);
            chk("head_seq", u_if.out_seq, exp_q[0].seq);
        end
    endtask

    // Entered #1 after a rising edge: check state, apply one cycle, advance the model.
    task automatic step(input bit en, input logic [31:0] p, input logic [31:0] ins, input bit rdy);
        bit   pop_m;
        rec_t r;
        check_status();
        cap_en      = en;
        pc          = p;
        instruction = ins;
        ALU_result  = $urandom;
        write_data  = $urandom;
        {RegWrite, MemRead, MemWrite} = 3'($urandom);
        u_if.out_ready = rdy;
        pop_m = (m_cnt > 0) && rdy;
        if (en && ins != 32'h0) begin
            if (m_cnt < DEPTH || pop_m) begin
                r.pc    = p;
                r.instr = ins;
                r.alu   = ALU_result;
                r.wdata = write_data;
                r.flags = {RegWrite, MemRead, MemWrite};
                r.seq   = m_seq;
                exp_q.push_back(r);
                m_cnt++;
            end else begin
                if (m_drop != 16'hFFFF) m_drop++;
                m_ovf = 1'b1;
            end
            m_seq++;
        end
        if (pop_m) m_cnt--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        cap_en         = 1'b0;
        instruction    = '0;
        u_if.out_ready = 1'b0;
        exp_q.delete();
        m_cnt  = 0;
        m_seq  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pc = '0; ALU_result = '0; write_data = '0;
        RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        do_reset(2);

        // In-order capture with the consumer stalled, then released
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), $urandom | 32'h1, 1'b0);
        chk("t1_count", count, 5);
        chk("t1_head_pc", u_if.out_pc, 0);
        chk("t1_head_seq", u_if.out_seq, 0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 1'b1);
        chk("t1_empty", empty, 1);

        // Zero instructions are bubbles
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100, 32'h0, 1'b0);
        step(1'b1, 32'h200, 32'h0000_0013, 1'b0);
        chk("t2_count", count, 1);
        chk("t2_seq", u_if.out_seq, 0);
        drain_all();

        // Overflow: 20 captures into 16 slots
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i * 4), $urandom | 32'h1, 1'b0);
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        chk("t3_drop", drop_cnt, 4);
        chk("t3_ovf", overflow, 1);
        // Full with simultaneous pop and capture: slot reused, no new drop
        step(1'b1, 32'h500, 32'hDEAD_BEEF, 1'b1);
        chk("t4_count", count, 16);
        chk("t4_drop", drop_cnt, 4);
        drain_all();

        // Streaming through pointer wrap
        do_reset(1);
        for (int i = 0; i < 40; i++) step(1'b1, 32'(i * 4), $urandom | 32'h1, 1'b1);
        chk("t5_count_le1", count <= 1, 1);
        chk("t5_drop", drop_cnt, 0);
        drain_all();

        // Reset mid-stream discards records and clears counters
        do_reset(1);
        for (int i = 0; i < 18; i++) step(1'b1, 32'(i * 4), $urandom | 32'h1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1);
        chk("t6_pre_count", count, 7);
        chk("t6_pre_drop", drop_cnt, 2);
        do_reset(1);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_ovf", overflow, 0);
        step(1'b1, 32'h40, 32'h0000_00B3, 1'b0);
        chk("t6_seq", u_if.out_seq, 0);
        drain_all();

        // Randomised traffic with varying consumer pressure
        do_reset(1);
        for (int ph = 0; ph < 8; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 2 == 0) ? 20 : 85;
            for (int i = 0; i < 50; i++) begin
                logic [31:0] ins;
                ins = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
                step($urandom_range(0, 3) != 0, $urandom, ins,
                     $urandom_range(0, 99) < rdy_pct);
            end
        end
        drain_all();
        step(1'b0, '0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
